issue_scheduler: RTL and testbench

Reservation station and issue arbiter in front of the `execute` stage. It holds up to DEPTH dispatched ALU ops and captures missing operands from the common data bus (CDB). Each cycle it picks the oldest entry whose operands are both ready and drives it to the execute unit through a registered valid/ready port. It is the only block that sequences the shared ALU datapath.

---
 rtl/ooo_pkg.sv | 53 +++++
 rtl/rs_oldest_select.sv | 62 ++++++
 rtl/issue_scheduler.sv | 161 ++++++++++++++++
 tb/tb_issue_scheduler.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_pkg.sv
// ooo_pkg: datapath widths, ALU function encoding and the reservation
// station entry shared by the out-of-order issue path.
package ooo_pkg;

   localparam int WORD     = 32;
   localparam int ADDR_LEN = 32;
   localparam int TAG_W    = 4;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'h0,
      ALU_SUB  = 4'h1,
      ALU_SLL  = 4'h2,
      ALU_SLT  = 4'h3,
      ALU_SLTU = 4'h4,
      ALU_XOR  = 4'h5,
      ALU_SRL  = 4'h6,
      ALU_SRA  = 4'h7,
      ALU_OR   = 4'h8,
      ALU_AND  = 4'h9
   } alu_func_e;

   typedef struct packed {
      logic             rdy;
      logic [TAG_W-1:0] tag;
      logic [WORD-1:0]  value;
   } rs_opnd_t;

   typedef struct packed {
      logic                valid;
      alu_func_e           func;
      rs_opnd_t            rs1;
      rs_opnd_t            rs2;
      logic [TAG_W-1:0]    dst_tag;
      logic [ADDR_LEN-1:0] pc;
   } rs_entry_t;

   // Capture a CDB broadcast into a still-pending operand.
   function automatic rs_opnd_t opnd_capture(
      input rs_opnd_t         o,
      input logic             cdb_v,
      input logic [TAG_W-1:0] cdb_t,
      input logic [WORD-1:0]  cdb_d
   );
      rs_opnd_t r;
      r = o;
      if (cdb_v && !o.rdy && (o.tag == cdb_t)) begin
         r.rdy   = 1'b1;
         r.value = cdb_d;
      end
      return r;
   endfunction

endpackage

// File: rtl/rs_oldest_select.sv
// rs_oldest_select: age matrix and oldest-eligible picker.
// Ports: clk, reset, clr_i (flush), valid_i, alloc_i, free_i, elig_i in; grant_o (one-hot), found_o out.
module rs_oldest_select
   import ooo_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic [DEPTH-1:0] valid_i,
   input  logic [DEPTH-1:0] alloc_i,
   input  logic [DEPTH-1:0] free_i,
   input  logic [DEPTH-1:0] elig_i,
   output logic [DEPTH-1:0] grant_o,
   output logic             found_o
);

   // age_q[i][j] = 1 : entry i is older than entry j
   logic [DEPTH-1:0][DEPTH-1:0] age_q;
   logic [DEPTH-1:0][DEPTH-1:0] age_d;

   always_comb begin
      age_d = age_q;
      // A new entry is younger than every entry already resident.
      for (int k = 0; k < DEPTH; k++) begin
         if (alloc_i[k]) begin
            age_d[k] = '0;
            for (int i = 0; i < DEPTH; i++)
               age_d[i][k] = valid_i[i];
         end
      end
      for (int k = 0; k < DEPTH; k++) begin
         if (free_i[k]) begin
            age_d[k] = '0;
            for (int i = 0; i < DEPTH; i++)
               age_d[i][k] = 1'b0;
         end
      end
   end

   // An eligible entry wins unless some other eligible entry is older.
   always_comb begin
      grant_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         grant_o[i] = elig_i[i];
         for (int j = 0; j < DEPTH; j++)
            if (elig_i[j] && age_q[j][i])
               grant_o[i] = 1'b0;
      end
   end

   assign found_o = |elig_i;

   always_ff @(posedge clk) begin
      if (reset || clr_i)
         age_q <= '0;
      else
         age_q <= age_d;
   end

endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: reservation station with CDB wakeup and oldest-first issue.
// Ports: dispatch (disp_*), CDB (cdb_*), registered issue port (iss_*); optional flush with ISSUE_SCHED_FLUSH_EN.
module issue_scheduler
   import ooo_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset,
`ifdef ISSUE_SCHED_FLUSH_EN
   input  logic                flush,
`endif
   input  logic                disp_valid,
   output logic                disp_ready,
   input  logic [3:0]          disp_alu_func,
   input  logic [WORD-1:0]     disp_rs1_value,
   input  logic [WORD-1:0]     disp_rs2_value,
   input  logic [TAG_W-1:0]    disp_rs1_tag,
   input  logic [TAG_W-1:0]    disp_rs2_tag,
   input  logic                disp_rs1_rdy,
   input  logic                disp_rs2_rdy,
   input  logic [TAG_W-1:0]    disp_dst_tag,
   input  logic [ADDR_LEN-1:0] disp_pc,
   input  logic                cdb_valid,
   input  logic [TAG_W-1:0]    cdb_tag,
   input  logic [WORD-1:0]     cdb_value,
   output logic                iss_valid,
   input  logic                iss_ready,
   output logic [3:0]          iss_alu_func,
   output logic [WORD-1:0]     iss_rs1_value,
   output logic [WORD-1:0]     iss_rs2_value,
   output logic [TAG_W-1:0]    iss_dst_tag,
   output logic [ADDR_LEN-1:0] iss_pc
);

   rs_entry_t        ent_q [DEPTH];
   rs_entry_t        ent_d [DEPTH];
   rs_entry_t        new_ent;
   rs_entry_t        sel_ent;
   rs_entry_t        iss_q;
   logic [DEPTH-1:0] valid_vec;
   logic [DEPTH-1:0] elig_vec;
   logic [DEPTH-1:0] alloc_vec;
   logic [DEPTH-1:0] free_vec;
   logic [DEPTH-1:0] grant;
   logic             found;
   logic             disp_fire;
   logic             iss_load;
   logic             flush_w;

`ifdef ISSUE_SCHED_FLUSH_EN
   assign flush_w = flush;
`else
   assign flush_w = 1'b0;
`endif

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         valid_vec[i] = ent_q[i].valid;
         elig_vec[i]  = ent_q[i].valid
                      && ent_q[i].rs1.rdy
                      && ent_q[i].rs2.rdy;
      end
   end

   assign disp_ready = ~&valid_vec;
   assign disp_fire  = disp_valid && disp_ready && !flush_w;
   assign iss_load   = (!iss_q.valid || iss_ready) && found && !flush_w;
   assign free_vec   = grant & {DEPTH{iss_load}};

   // Lowest-index free slot; descending scan lets the lowest win.
   always_comb begin
      alloc_vec = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_vec[i]) begin
            alloc_vec    = '0;
            alloc_vec[i] = disp_fire;
         end
      end
   end

   always_comb begin
      new_ent.valid     = 1'b1;
      new_ent.func      = alu_func_e'(disp_alu_func);
      new_ent.rs1.rdy   = disp_rs1_rdy;
      new_ent.rs1.tag   = disp_rs1_tag;
      new_ent.rs1.value = disp_rs1_value;
      new_ent.rs2.rdy   = disp_rs2_rdy;
      new_ent.rs2.tag   = disp_rs2_tag;
      new_ent.rs2.value = disp_rs2_value;
      new_ent.dst_tag   = disp_dst_tag;
      new_ent.pc        = disp_pc;
      // same-cycle CDB bypass into the op being written
      new_ent.rs1 = opnd_capture(new_ent.rs1, cdb_valid, cdb_tag, cdb_value);
      new_ent.rs2 = opnd_capture(new_ent.rs2, cdb_valid, cdb_tag, cdb_value);
   end

   always_comb begin
      sel_ent = '0;
      for (int i = 0; i < DEPTH; i++)
         if (grant[i])
            sel_ent = ent_q[i];
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent_d[i] = ent_q[i];
         if (ent_q[i].valid) begin
            ent_d[i].rs1 = opnd_capture(ent_q[i].rs1, cdb_valid, cdb_tag, cdb_value);
            ent_d[i].rs2 = opnd_capture(ent_q[i].rs2, cdb_valid, cdb_tag, cdb_value);
         end
         if (free_vec[i])
            ent_d[i].valid = 1'b0;
         if (alloc_vec[i])
            ent_d[i] = new_ent;
         if (flush_w)
            ent_d[i].valid = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (reset)
            ent_q[i] <= '0;
         else
            ent_q[i] <= ent_d[i];
      end
   end

   rs_oldest_select #(
      .DEPTH (DEPTH)
   ) u_sel (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (flush_w),
      .valid_i (valid_vec),
      .alloc_i (alloc_vec),
      .free_i  (free_vec),
      .elig_i  (elig_vec),
      .grant_o (grant),
      .found_o (found)
   );

   // Output register; iss_q.valid doubles as iss_valid.
   always_ff @(posedge clk) begin
      if (reset || flush_w)
         iss_q <= '0;
      else if (iss_load)
         iss_q <= sel_ent;
      else if (iss_ready)
         iss_q.valid <= 1'b0;
   end

   assign iss_valid     = iss_q.valid;
   assign iss_alu_func  = iss_q.func;
   assign iss_rs1_value = iss_q.rs1.value;
   assign iss_rs2_value = iss_q.rs2.value;
   assign iss_dst_tag   = iss_q.dst_tag;
   assign iss_pc        = iss_q.pc;

endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: directed scenarios plus a randomized run checked
// against a queue-based age-ordered model of the reservation station.
module tb_issue_scheduler;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
`ifdef ISSUE_SCHED_FLUSH_EN
   logic        flush;
`endif
   logic        disp_valid;
   logic        disp_ready;
   logic [3:0]  disp_alu_func;
   logic [31:0] disp_rs1_value;
   logic [31:0] disp_rs2_value;
   logic [3:0]  disp_rs1_tag;
   logic [3:0]  disp_rs2_tag;
   logic        disp_rs1_rdy;
   logic        disp_rs2_rdy;
   logic [3:0]  disp_dst_tag;
   logic [31:0] disp_pc;
   logic        cdb_valid;
   logic [3:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic        iss_valid;
   logic        iss_ready;
   logic [3:0]  iss_alu_func;
   logic [31:0] iss_rs1_value;
   logic [31:0] iss_rs2_value;
   logic [3:0]  iss_dst_tag;
   logic [31:0] iss_pc;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [3:0]  func;
      logic        r1;
      logic        r2;
      logic [3:0]  t1;
      logic [3:0]  t2;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [3:0]  dst;
      logic [31:0] pc;
   } m_op_t;

   m_op_t mq[$];
   logic  m_ov;
   m_op_t m_out;

   always #5 clk = ~clk;

   issue_scheduler #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
`ifdef ISSUE_SCHED_FLUSH_EN
      .flush          (flush),
`endif
      .disp_valid     (disp_valid),
      .disp_ready     (disp_ready),
      .disp_alu_func  (disp_alu_func),
      .disp_rs1_value (disp_rs1_value),
      .disp_rs2_value (disp_rs2_value),
      .disp_rs1_tag   (disp_rs1_tag),
      .disp_rs2_tag   (disp_rs2_tag),
      .disp_rs1_rdy   (disp_rs1_rdy),
      .disp_rs2_rdy   (disp_rs2_rdy),
      .disp_dst_tag   (disp_dst_tag),
      .disp_pc        (disp_pc),
      .cdb_valid      (cdb_valid),
      .cdb_tag        (cdb_tag),
      .cdb_value      (cdb_value),
      .iss_valid      (iss_valid),
      .iss_ready      (iss_ready),
      .iss_alu_func   (iss_alu_func),
      .iss_rs1_value  (iss_rs1_value),
      .iss_rs2_value  (iss_rs2_value),
      .iss_dst_tag    (iss_dst_tag),
      .iss_pc         (iss_pc)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      disp_valid = 1'b0;
      cdb_valid  = 1'b0;
   endtask

   task automatic set_disp(input logic [3:0] f,
                           input logic [31:0] v1, input logic r1, input logic [3:0] t1,
                           input logic [31:0] v2, input logic r2, input logic [3:0] t2,
                           input logic [3:0] dst, input logic [31:0] pc);
      disp_valid     = 1'b1;
      disp_alu_func  = f;
      disp_rs1_value = v1;
      disp_rs1_rdy   = r1;
      disp_rs1_tag   = t1;
      disp_rs2_value = v2;
      disp_rs2_rdy   = r2;
      disp_rs2_tag   = t2;
      disp_dst_tag   = dst;
      disp_pc        = pc;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      iss_ready = 1'b0;
`ifdef ISSUE_SCHED_FLUSH_EN
      flush     = 1'b0;
`endif
      idle();
      set_disp(4'h0, 0, 1'b0, 0, 0, 1'b0, 0, 0, 0);
      disp_valid = 1'b0;
      cdb_tag    = 4'h0;
      cdb_value  = 32'h0;
      cyc();
      cyc();
      reset = 1'b0;
      total++;
      if (iss_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_iss_valid got=%b want=0", iss_valid);
      end
      total++;
      if (disp_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_disp_ready got=%b want=1", disp_ready);
      end
      total++;
      if ({iss_alu_func, iss_rs1_value, iss_rs2_value, iss_dst_tag, iss_pc} !== '0) begin
         bad++;
         $display("FAIL reset_payload got=%h/%h/%h/%h/%h want=0",
                  iss_alu_func, iss_rs1_value, iss_rs2_value, iss_dst_tag, iss_pc);
      end
   endtask

   task automatic test_basic_latency();
      iss_ready = 1'b1;
      set_disp(4'h0, 32'd5, 1'b1, 4'h0, 32'd7, 1'b1, 4'h0, 4'd3, 32'h100);
      cyc();
      idle();
      total++;
      if (iss_valid !== 1'b0) begin
         bad++;
         $display("FAIL lat_early got=%b want=0", iss_valid);
      end
      cyc();
      total++;
      if ({iss_valid, iss_alu_func, iss_rs1_value, iss_rs2_value, iss_dst_tag, iss_pc}
          !== {1'b1, 4'h0, 32'd5, 32'd7, 4'd3, 32'h100}) begin
         bad++;
         $display("FAIL lat_issue got v=%b f=%h a=%0d b=%0d d=%0d pc=%h want v=1 f=0 a=5 b=7 d=3 pc=100",
                  iss_valid, iss_alu_func, iss_rs1_value, iss_rs2_value, iss_dst_tag, iss_pc);
      end
      cyc();
      total++;
      if ({iss_valid, disp_ready} !== 2'b01) begin
         bad++;
         $display("FAIL lat_drain got v=%b rdy=%b want v=0 rdy=1", iss_valid, disp_ready);
      end
   endtask

   task automatic test_order_wakeup();
      iss_ready = 1'b1;
      set_disp(4'h1, 32'd0, 1'b0, 4'd2, 32'd1, 1'b1, 4'd0, 4'd4, 32'h200);
      cyc();
      set_disp(4'h2, 32'd3, 1'b1, 4'd0, 32'd4, 1'b1, 4'd0, 4'd5, 32'h204);
      cyc();
      idle();
      cyc();
      total++;
      if ({iss_valid, iss_dst_tag, iss_rs1_value} !== {1'b1, 4'd5, 32'd3}) begin
         bad++;
         $display("FAIL order_b_first got v=%b d=%0d a=%0d want v=1 d=5 a=3",
                  iss_valid, iss_dst_tag, iss_rs1_value);
      end
      cdb_valid = 1'b1;
      cdb_tag   = 4'd2;
      cdb_value = 32'd9;
      cyc();
      idle();
      total++;
      if (iss_valid !== 1'b0) begin
         bad++;
         $display("FAIL order_wake_gap got=%b want=0", iss_valid);
      end
      cyc();
      total++;
      if ({iss_valid, iss_dst_tag, iss_rs1_value, iss_rs2_value}
          !== {1'b1, 4'd4, 32'd9, 32'd1}) begin
         bad++;
         $display("FAIL order_a_woken got v=%b d=%0d a=%0d b=%0d want v=1 d=4 a=9 b=1",
                  iss_valid, iss_dst_tag, iss_rs1_value, iss_rs2_value);
      end
      cyc();
   endtask

   task automatic test_full();
      iss_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         set_disp(4'h3, 32'd0, 1'b0, 4'(8 + i), 32'(i), 1'b1, 4'd0, 4'(i), 32'(i));
         cyc();
      end
      total++;
      if (disp_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_ready got=%b want=0", disp_ready);
      end
      set_disp(4'h3, 32'd0, 1'b0, 4'd12, 32'd0, 1'b1, 4'd0, 4'd15, 32'd0);
      cyc();
      idle();
      total++;
      if ({disp_ready, iss_valid} !== 2'b00) begin
         bad++;
         $display("FAIL full_5th got rdy=%b v=%b want rdy=0 v=0", disp_ready, iss_valid);
      end
      cdb_valid = 1'b1;
      cdb_tag   = 4'd8;
      cdb_value = 32'h80;
      cyc();
      idle();
      total++;
      if (disp_ready !== 1'b0) begin
         bad++;
         $display("FAIL full_woken_ready got=%b want=0", disp_ready);
      end
      cyc();
      total++;
      if ({disp_ready, iss_valid, iss_rs1_value, iss_dst_tag} !== {1'b1, 1'b1, 32'h80, 4'd0}) begin
         bad++;
         $display("FAIL full_freed got rdy=%b v=%b a=%h d=%0d want rdy=1 v=1 a=80 d=0",
                  disp_ready, iss_valid, iss_rs1_value, iss_dst_tag);
      end
      for (int t = 9; t < 12; t++) begin
         cdb_valid = 1'b1;
         cdb_tag   = 4'(t);
         cdb_value = 32'(t);
         cyc();
      end
      idle();
      repeat (4) cyc();
      total++;
      if ({iss_valid, disp_ready} !== 2'b01) begin
         bad++;
         $display("FAIL full_drain got v=%b rdy=%b want v=0 rdy=1", iss_valid, disp_ready);
      end
   endtask

   task automatic test_hold();
      iss_ready = 1'b0;
      set_disp(4'h5, 32'h11, 1'b1, 4'd0, 32'h1, 1'b1, 4'd0, 4'd1, 32'h300);
      cyc();
      set_disp(4'h6, 32'h22, 1'b1, 4'd0, 32'h2, 1'b1, 4'd0, 4'd2, 32'h304);
      cyc();
      idle();
      for (int k = 0; k < 3; k++) begin
         total++;
         if ({iss_valid, iss_dst_tag, iss_rs1_value, iss_pc} !== {1'b1, 4'd1, 32'h11, 32'h300}) begin
            bad++;
            $display("FAIL hold_%0d got v=%b d=%0d a=%h pc=%h want v=1 d=1 a=11 pc=300",
                     k, iss_valid, iss_dst_tag, iss_rs1_value, iss_pc);
         end
         cyc();
      end
      iss_ready = 1'b1;
      cyc();
      total++;
      if ({iss_valid, iss_dst_tag, iss_rs1_value} !== {1'b1, 4'd2, 32'h22}) begin
         bad++;
         $display("FAIL hold_younger got v=%b d=%0d a=%h want v=1 d=2 a=22",
                  iss_valid, iss_dst_tag, iss_rs1_value);
      end
      cyc();
      total++;
      if (iss_valid !== 1'b0) begin
         bad++;
         $display("FAIL hold_empty got=%b want=0", iss_valid);
      end
   endtask

   task automatic test_bypass();
      iss_ready = 1'b1;
      set_disp(4'h7, 32'h3, 1'b1, 4'd0, 32'h0, 1'b0, 4'd6, 4'd9, 32'h400);
      cdb_valid = 1'b1;
      cdb_tag   = 4'd6;
      cdb_value = 32'h55;
      cyc();
      idle();
      cyc();
      total++;
      if ({iss_valid, iss_rs1_value, iss_rs2_value, iss_dst_tag}
          !== {1'b1, 32'h3, 32'h55, 4'd9}) begin
         bad++;
         $display("FAIL bypass got v=%b a=%h b=%h d=%0d want v=1 a=3 b=55 d=9",
                  iss_valid, iss_rs1_value, iss_rs2_value, iss_dst_tag);
      end
      cyc();
   endtask

`ifdef ISSUE_SCHED_FLUSH_EN
   task automatic test_flush();
      iss_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_disp(4'h8, 32'(i), 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 4'(1 + i), 32'h500);
         cyc();
      end
      idle();
      set_disp(4'h8, 32'd9, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 4'd14, 32'h5ff);
      flush = 1'b1;
      cyc();
      flush = 1'b0;
      idle();
      total++;
      if ({iss_valid, disp_ready} !== 2'b01) begin
         bad++;
         $display("FAIL flush_clear got v=%b rdy=%b want v=0 rdy=1", iss_valid, disp_ready);
      end
      iss_ready = 1'b1;
      cyc();
      total++;
      if (iss_valid !== 1'b0) begin
         bad++;
         $display("FAIL flush_dropped got=%b want=0", iss_valid);
      end
      set_disp(4'h9, 32'h7, 1'b1, 4'd0, 32'h8, 1'b1, 4'd0, 4'd7, 32'h600);
      cyc();
      idle();
      cyc();
      total++;
      if ({iss_valid, iss_dst_tag, iss_rs1_value} !== {1'b1, 4'd7, 32'h7}) begin
         bad++;
         $display("FAIL flush_after got v=%b d=%0d a=%h want v=1 d=7 a=7",
                  iss_valid, iss_dst_tag, iss_rs1_value);
      end
      cyc();
   endtask
`endif

   task automatic test_random();
      m_op_t n;
      int    e;
      logic  fire;
      reset = 1'b1;
      idle();
      cyc();
      reset = 1'b0;
      mq.delete();
      m_ov = 1'b0;
      for (int c = 0; c < 800; c++) begin
         disp_valid     = ($urandom_range(0, 2) != 0);
         disp_alu_func  = 4'($urandom);
         disp_rs1_value = $urandom;
         disp_rs2_value = $urandom;
         disp_rs1_tag   = 4'($urandom);
         disp_rs2_tag   = 4'($urandom);
         disp_rs1_rdy   = ($urandom_range(0, 2) != 0);
         disp_rs2_rdy   = ($urandom_range(0, 2) != 0);
         disp_dst_tag   = 4'($urandom);
         disp_pc        = $urandom;
         cdb_valid      = ($urandom_range(0, 1) != 0);
         cdb_tag        = 4'($urandom);
         cdb_value      = $urandom;
         iss_ready      = ($urandom_range(0, 3) != 0);
         total++;
         if (disp_ready !== (mq.size() < DEPTH)) begin
            bad++;
            $display("FAIL rnd_ready c=%0d got=%b want=%b", c, disp_ready, mq.size() < DEPTH);
         end
         @(posedge clk);
         fire = disp_valid && (mq.size() < DEPTH);
         e = -1;
         for (int i = 0; i < mq.size(); i++)
            if (e < 0 && mq[i].r1 && mq[i].r2)
               e = i;
         if ((!m_ov || iss_ready) && e >= 0) begin
            m_ov  = 1'b1;
            m_out = mq[e];
            mq.delete(e);
         end else if (iss_ready) begin
            m_ov = 1'b0;
         end
         for (int i = 0; i < mq.size(); i++) begin
            if (cdb_valid && !mq[i].r1 && mq[i].t1 == cdb_tag) begin
               mq[i].r1 = 1'b1;
               mq[i].v1 = cdb_value;
            end
            if (cdb_valid && !mq[i].r2 && mq[i].t2 == cdb_tag) begin
               mq[i].r2 = 1'b1;
               mq[i].v2 = cdb_value;
            end
         end
         if (fire) begin
            n.func = disp_alu_func;
            n.r1   = disp_rs1_rdy;
            n.t1   = disp_rs1_tag;
            n.v1   = disp_rs1_value;
            n.r2   = disp_rs2_rdy;
            n.t2   = disp_rs2_tag;
            n.v2   = disp_rs2_value;
            n.dst  = disp_dst_tag;
            n.pc   = disp_pc;
            if (cdb_valid && !n.r1 && n.t1 == cdb_tag) begin
               n.r1 = 1'b1;
               n.v1 = cdb_value;
            end
            if (cdb_valid && !n.r2 && n.t2 == cdb_tag) begin
               n.r2 = 1'b1;
               n.v2 = cdb_value;
            end
            mq.push_back(n);
         end
         #1;
         total++;
         if (iss_valid !== m_ov) begin
            bad++;
            $display("FAIL rnd_valid c=%0d got=%b want=%b", c, iss_valid, m_ov);
         end else if (m_ov) begin
            total++;
            if ({iss_alu_func, iss_rs1_value, iss_rs2_value, iss_dst_tag, iss_pc}
                !== {m_out.func, m_out.v1, m_out.v2, m_out.dst, m_out.pc}) begin
               bad++;
               $display("FAIL rnd_payload c=%0d got %h/%h/%h/%h/%h want %h/%h/%h/%h/%h", c,
                        iss_alu_func, iss_rs1_value, iss_rs2_value, iss_dst_tag, iss_pc,
                        m_out.func, m_out.v1, m_out.v2, m_out.dst, m_out.pc);
            end
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_basic_latency();
      test_order_wakeup();
      test_full();
      test_hold();
      test_bypass();
`ifdef ISSUE_SCHED_FLUSH_EN
      test_flush();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
